gray_threshold: RTL and testbench

Binarization stage that sits directly downstream of the BGR-to-gray converter. It reads the gray BMP image that stage leaves in memory: a byte header followed by B=G=R pixel triplets. It makes two passes over that image. The first pass computes the global mean gray level; the second copies the header and writes a black/white BMP with every pixel set to 0 or 255 by comparison against that mean. The block drives a synchronous source memory on the read side and a destination memory on the write side, and raises `done` on completion.

---
 rtl/gray_threshold_if.sv | 27 ++
 rtl/gray_threshold.sv | 187 ++++++++++++++++++
 tb/tb_gray_threshold.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/gray_threshold_if.sv
// Handshake/memory bundle between the binarization stage and its environment.
// The master side issues the start pulse and returns source bytes; the slave
// side (the gray_threshold block) drives both memory ports and the status.
interface gray_threshold_if #(
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 20
);
    logic                  in_valid;
    logic [BYTE_WIDTH-1:0] src_data;
    logic                  src_ren;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic                  dst_wen;
    logic [ADDR_WIDTH-1:0] dst_addr;
    logic [BYTE_WIDTH-1:0] dst_data;
    logic [BYTE_WIDTH-1:0] threshold;
    logic                  done;

    modport master (
        output in_valid, src_data,
        input  src_ren, src_addr, dst_wen, dst_addr, dst_data, threshold, done
    );

    modport slave (
        input  in_valid, src_data,
        output src_ren, src_addr, dst_wen, dst_addr, dst_data, threshold, done
    );
endinterface

// File: rtl/gray_threshold.sv
// Global-mean binarization of a gray BMP (B=G=R triplets after a byte header).
// Pass 1 averages the B bytes, pass 2 copies the header and writes 0/255 pixels.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   S_IDLE     | waiting for in_valid
//   S_SUM      | one B-byte read per cycle, accumulating the previous return
//   S_SUM_TAIL | accumulate the last returned byte
//   S_DIV      | restoring divide sum / PIXEL_COUNT, one quotient bit per cycle
//   S_HDR      | read header byte i; byte i-1 is written this cycle
//   S_BIN_RD   | read B byte of pixel k (last header write lands here)
//   S_BIN_WR   | write 0/255 to the three bytes of pixel k
//   S_DONE     | done=1, waiting for a restart
module gray_threshold #(
    parameter int BYTE_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 20,
    parameter int HEADER_SIZE = 54,
    parameter int PIXEL_COUNT = 262144,
    parameter int SUM_W       = BYTE_WIDTH + $clog2(PIXEL_COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    gray_threshold_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SUM, S_SUM_TAIL, S_DIV, S_HDR, S_BIN_RD, S_BIN_WR, S_DONE
    } state_t;

    localparam int CNT_W = SUM_W;
    localparam logic [ADDR_WIDTH-1:0] HDR_BASE = ADDR_WIDTH'(HEADER_SIZE);
    localparam logic [ADDR_WIDTH-1:0] HDR_LAST = ADDR_WIDTH'(HEADER_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] PIX_STEP = ADDR_WIDTH'(3);
    localparam logic [CNT_W-1:0]      PIX_LAST = CNT_W'(PIXEL_COUNT - 1);
    localparam logic [CNT_W-1:0]      DIV_LAST = CNT_W'(SUM_W - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

    state_t                r_state;
    logic [SUM_W-1:0]      r_acc;
    logic [SUM_W-2:0]      r_rem;
    logic [CNT_W-1:0]      r_cnt;
    logic [1:0]            r_sub;
    logic                  r_src_ren;
    logic [ADDR_WIDTH-1:0] r_src_addr;
    logic                  r_dst_wen;
    logic [ADDR_WIDTH-1:0] r_dst_addr;
    logic [BYTE_WIDTH-1:0] r_dst_data;
    logic [BYTE_WIDTH-1:0] r_threshold;
    logic                  r_done;
    logic                  r_pass_hdr;
    logic                  r_pass_bin;

    logic [SUM_W-1:0]      w_rem_sh;
    logic                  w_ge;
    logic [SUM_W-2:0]      w_diff;
    logic [SUM_W-1:0]      w_quo;
    logic [BYTE_WIDTH-1:0] w_bin;
    logic [BYTE_WIDTH-1:0] w_dst_data;

    // Remainder stays below PIXEL_COUNT, so the difference fits one bit narrower.
    assign w_rem_sh = {r_rem, r_acc[SUM_W-1]};
    assign w_ge     = (w_rem_sh >= SUM_W'(PIXEL_COUNT));
    assign w_diff   = w_rem_sh[SUM_W-2:0] - (SUM_W-1)'(PIXEL_COUNT);
    assign w_quo    = {r_acc[SUM_W-2:0], w_ge};

    // The source returns data in the cycle the write must happen, so the write
    // data is steered straight from src_data on those cycles and held otherwise.
    assign w_bin      = (bus.src_data >= r_threshold) ? {BYTE_WIDTH{1'b1}} : '0;
    assign w_dst_data = r_pass_hdr ? bus.src_data : (r_pass_bin ? w_bin : r_dst_data);

    assign bus.src_ren   = r_src_ren;
    assign bus.src_addr  = r_src_addr;
    assign bus.dst_wen   = r_dst_wen;
    assign bus.dst_addr  = r_dst_addr;
    assign bus.dst_data  = w_dst_data;
    assign bus.threshold = r_threshold;
    assign bus.done      = r_done;

    // Sequencer: state, datapath registers and registered memory controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_sub       <= '0;
            r_src_ren   <= 1'b0;
            r_src_addr  <= '0;
            r_dst_wen   <= 1'b0;
            r_dst_addr  <= '0;
            r_dst_data  <= '0;
            r_threshold <= '0;
            r_done      <= 1'b0;
            r_pass_hdr  <= 1'b0;
            r_pass_bin  <= 1'b0;
        end else begin
            r_pass_hdr <= 1'b0;
            r_pass_bin <= 1'b0;
            if (r_pass_hdr || r_pass_bin) begin
                r_dst_data <= w_dst_data;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.in_valid) begin
                        r_state     <= S_SUM;
                        r_acc       <= '0;
                        r_rem       <= '0;
                        r_cnt       <= '0;
                        r_sub       <= '0;
                        r_threshold <= '0;
                        r_done      <= 1'b0;
                        r_src_ren   <= 1'b1;
                        r_src_addr  <= HDR_BASE;
                    end
                end
                S_SUM: begin
                    if (r_cnt != '0) begin
                        r_acc <= r_acc + SUM_W'(bus.src_data);
                    end
                    if (r_cnt == PIX_LAST) begin
                        r_state   <= S_SUM_TAIL;
                        r_src_ren <= 1'b0;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt      <= r_cnt + CNT_ONE;
                        r_src_addr <= r_src_addr + PIX_STEP;
                    end
                end
                S_SUM_TAIL: begin
                    r_acc   <= r_acc + SUM_W'(bus.src_data);
                    r_rem   <= '0;
                    r_cnt   <= '0;
                    r_state <= S_DIV;
                end
                S_DIV: begin
                    r_rem <= w_ge ? w_diff : w_rem_sh[SUM_W-2:0];
                    r_acc <= w_quo;
                    if (r_cnt == DIV_LAST) begin
                        r_threshold <= w_quo[BYTE_WIDTH-1:0];
                        r_state     <= S_HDR;
                        r_src_ren   <= 1'b1;
                        r_src_addr  <= '0;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_HDR: begin
                    r_dst_wen  <= 1'b1;
                    r_dst_addr <= r_src_addr;
                    r_pass_hdr <= 1'b1;
                    if (r_src_addr == HDR_LAST) begin
                        r_state    <= S_BIN_RD;
                        r_src_addr <= HDR_BASE;
                    end else begin
                        r_src_addr <= r_src_addr + ADDR_WIDTH'(1);
                    end
                end
                S_BIN_RD: begin
                    r_src_ren  <= 1'b0;
                    r_dst_wen  <= 1'b1;
                    r_dst_addr <= r_src_addr;
                    r_pass_bin <= 1'b1;
                    r_sub      <= '0;
                    r_state    <= S_BIN_WR;
                end
                S_BIN_WR: begin
                    if (r_sub == 2'd2) begin
                        r_dst_wen <= 1'b0;
                        if (r_cnt == PIX_LAST) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_BIN_RD;
                            r_src_ren  <= 1'b1;
                            r_src_addr <= r_src_addr + PIX_STEP;
                            r_cnt      <= r_cnt + CNT_ONE;
                        end
                    end else begin
                        r_sub      <= r_sub + 2'd1;
                        r_dst_addr <= r_dst_addr + ADDR_WIDTH'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gray_threshold.sv
// Bench for gray_threshold with a 4-byte header and 4 pixels (16-byte image).
// Stimulus pushes the hand-computed destination writes into a queue; a negedge
// monitor pops and compares each write the block makes.
module tb_gray_threshold;
    localparam int H  = 4;
    localparam int P  = 4;
    localparam int NB = H + 3 * P;
    localparam int SW = 11;
    localparam int LAT = 1 + P + 1 + SW + H + 4 * P;

    typedef struct packed {
        logic [19:0] a;
        logic [7:0]  d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gray_threshold_if #(.BYTE_WIDTH(8), .ADDR_WIDTH(20)) bus ();

    gray_threshold #(
        .BYTE_WIDTH(8), .ADDR_WIDTH(20), .HEADER_SIZE(H), .PIXEL_COUNT(P)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] mem [NB];
    int total  = 0;
    int bad    = 0;
    int wr_cnt = 0;
    wr_t q[$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Synchronous source memory: data appears the cycle after a read.
    always @(posedge clk) begin
        if (bus.src_ren) bus.src_data <= mem[bus.src_addr[3:0]];
    end

    // Monitor: address range checks and scoreboard pops on every write.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.src_ren) chk("src_addr_range", int'(bus.src_addr < 20'(NB)), 1);
            if (bus.dst_wen) begin
                wr_cnt++;
                chk("dst_addr_range", int'(bus.dst_addr < 20'(NB)), 1);
                if (q.size() == 0) begin
                    chk("unexpected_write", int'(bus.dst_addr), -1);
                end else begin
                    wr_t e;
                    e = q.pop_front();
                    chk("wr_addr", int'(bus.dst_addr), int'(e.a));
                    chk("wr_data", int'(bus.dst_data), int'(e.d));
                end
            end
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_src_ren"},   int'(bus.src_ren), 0);
        chk({tag, "_dst_wen"},   int'(bus.dst_wen), 0);
        chk({tag, "_done"},      int'(bus.done), 0);
        chk({tag, "_src_addr"},  int'(bus.src_addr), 0);
        chk({tag, "_dst_addr"},  int'(bus.dst_addr), 0);
        chk({tag, "_dst_data"},  int'(bus.dst_data), 0);
        chk({tag, "_threshold"}, int'(bus.threshold), 0);
    endtask

    // hb: first header byte (header is hb, hb+1, ...); bw: expected 0/255 per pixel.
    task automatic run_job(input logic [7:0] hb, input logic [3:0][7:0] pix,
                           input logic [7:0] thr, input logic [3:0][7:0] bw,
                           input bit noise, input int stop_at);
        int  n;
        int  w0;
        bit  got;
        wr_t e;
        for (int i = 0; i < H; i++) begin
            mem[i] = hb + 8'(i);
            e.a = 20'(i);
            e.d = hb + 8'(i);
            q.push_back(e);
        end
        for (int k = 0; k < P; k++) begin
            for (int j = 0; j < 3; j++) begin
                mem[H + 3 * k + j] = pix[k];
                e.a = 20'(H + 3 * k + j);
                e.d = bw[k];
                q.push_back(e);
            end
        end
        w0  = wr_cnt;
        got = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        n = 1;
        while (n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            if (n == stop_at) break;
            bus.in_valid = noise && (n == 3 || n == 10);
        end
        bus.in_valid = 1'b0;
        if (stop_at == 0) begin
            chk("done_latency", got ? n : -1, LAT);
            chk("threshold", int'(bus.threshold), int'(thr));
            chk("write_count", wr_cnt - w0, NB);
            chk("scoreboard_empty", q.size(), 0);
            @(negedge clk);
            chk("done_hold", int'(bus.done), 1);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < NB; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1 check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 10,20,30,40 -> mean 25
        run_job(8'hA1, {8'd40, 8'd30, 8'd20, 8'd10}, 8'd25,
                {8'hFF, 8'hFF, 8'h00, 8'h00}, 1'b0, 0);
        // 0,0,0,1 -> floor(0.25)=0, ties are white
        run_job(8'hB1, {8'd1, 8'd0, 8'd0, 8'd0}, 8'd0,
                {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 1'b0, 0);
        // all 255 -> sum 1020, mean 255
        run_job(8'hC1, {8'd255, 8'd255, 8'd255, 8'd255}, 8'd255,
                {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 1'b0, 0);

        // Abort inside BIN_WR of pixel 0, then rerun from scratch.
        run_job(8'hA1, {8'd40, 8'd30, 8'd20, 8'd10}, 8'd25,
                {8'hFF, 8'hFF, 8'h00, 8'h00}, 1'b0, 23);
        rst_n = 1'b0;
        #1 check_idle("mid_reset");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_job(8'hA1, {8'd40, 8'd30, 8'd20, 8'd10}, 8'd25,
                {8'hFF, 8'hFF, 8'h00, 8'h00}, 1'b0, 0);

        // Stray starts during SUM and DIV, then a restart straight from DONE.
        run_job(8'hA1, {8'd40, 8'd30, 8'd20, 8'd10}, 8'd25,
                {8'hFF, 8'hFF, 8'h00, 8'h00}, 1'b1, 0);
        run_job(8'hA1, {8'd40, 8'd30, 8'd20, 8'd10}, 8'd25,
                {8'hFF, 8'hFF, 8'h00, 8'h00}, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
